// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I core pipeline.
// Holds the load/store funct3 encodings, the MEM-stage FSM state type and
// a helper that classifies funct3 into an access size.
package cpu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_RESP = 2'd2,
    MS_DONE = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } acc_size_e;

  // Unused encodings (011, 110, 111) fall through to word accesses.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    acc_size_e sz;
    case (f3)
      F3_LB, F3_LBU: sz = ACC_BYTE;
      F3_LH, F3_LHU: sz = ACC_HALF;
      default:       sz = ACC_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational load-data lane select and sign/zero extension.
// Ports:
//   i_rdata  [31:0] raw bus read word
//   i_addr   [1:0]  byte offset of the access
//   i_funct3 [2:0]  load width/sign
//   o_data   [31:0] extended result
// Half accesses use only i_addr[1]; word accesses ignore i_addr.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  assign w_unsigned = i_funct3[2];

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (f3_size(i_funct3))
      ACC_BYTE: o_data = w_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      ACC_HALF: o_data = w_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage of the RV32I core.
// Issues loads/stores on a req/gnt/rvalid data bus, aligns store data and
// byte enables, extends load data, and stalls upstream until the access is
// complete. Non-memory instructions pass straight to rd_* combinationally.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_*                     instruction held in the EX/MEM register
//   dmem_*                   data-memory bus (word-aligned address)
//   rd_we_o/rd_addr_o/rd_data_o  writeback towards MEM/WB
//   stall_o                  freeze EX/MEM and earlier stages
// Build option MEM_MISALIGN_EXC_EN: adds misalign_o/misalign_addr_o and
// rejects misaligned half/word accesses instead of forcing alignment.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic              ex_rd_we_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic [XLEN-1:0]   ex_alu_res_i,
  input  logic [XLEN-1:0]   ex_store_data_i,
  input  logic              ex_mem_re_i,
  input  logic              ex_mem_we_i,
  input  logic [2:0]        ex_funct3_i,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
`ifdef MEM_MISALIGN_EXC_EN
  output logic              misalign_o,
  output logic [31:0]       misalign_addr_o,
`endif
  output logic              rd_we_o,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              stall_o
);

  mem_state_e  r_state, w_state_nxt;

  logic [4:0]        r_rd_addr;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [XLEN-1:0]   r_wdata;
  logic              r_is_load;
  logic [XLEN-1:0]   r_result;

  acc_size_e   w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;
  logic        w_is_mem;
  logic        w_mis;
  logic        w_start;

  assign w_size   = f3_size(ex_funct3_i);
  assign w_is_mem = ex_mem_re_i | ex_mem_we_i;

  always_comb begin
    case (w_size)
      ACC_BYTE: begin
        w_be    = 4'b0001 << ex_alu_res_i[1:0];
        w_wdata = {4{ex_store_data_i[7:0]}};
      end
      ACC_HALF: begin
        w_be    = 4'b0011 << {ex_alu_res_i[1], 1'b0};
        w_wdata = {2{ex_store_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = ex_store_data_i;
      end
    endcase
  end

`ifdef MEM_MISALIGN_EXC_EN
  assign w_mis = ((w_size == ACC_HALF) && ex_alu_res_i[0]) ||
                 ((w_size == ACC_WORD) && (ex_alu_res_i[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  load_align u_load_align (
    .i_rdata  (dmem_rdata),
    .i_addr   (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_load_ext)
  );

  // Bus fields come only from latched state so they stay stable until gnt.
  assign dmem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = r_wdata;
  assign dmem_we    = (r_state == MS_REQ) && !r_is_load;
  assign dmem_be    = (r_state == MS_REQ) ? r_be : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MS_IDLE;
      r_rd_addr <= '0;
      r_funct3  <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_is_load <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_rd_addr <= ex_rd_addr_i;
        r_funct3  <= ex_funct3_i;
        r_addr    <= ex_alu_res_i[ADDR_W-1:0];
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_is_load <= ex_mem_re_i;
        r_result  <= '0;
      end
      if ((r_state == MS_RESP) && dmem_rvalid) begin
        r_result <= w_load_ext;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    dmem_req    = 1'b0;
    stall_o     = 1'b0;
    rd_we_o     = 1'b0;
    rd_addr_o   = ex_rd_addr_i;
    rd_data_o   = ex_alu_res_i;
`ifdef MEM_MISALIGN_EXC_EN
    misalign_o      = 1'b0;
    misalign_addr_o = '0;
`endif
    case (r_state)
      MS_IDLE: begin
        if (ex_valid_i) begin
          if (w_is_mem) begin
            if (w_mis) begin
`ifdef MEM_MISALIGN_EXC_EN
              misalign_o      = 1'b1;
              misalign_addr_o = ex_alu_res_i;
`endif
            end else begin
              w_start     = 1'b1;
              stall_o     = 1'b1;
              w_state_nxt = MS_REQ;
            end
          end else begin
            rd_we_o = ex_rd_we_i;
          end
        end
      end
      MS_REQ: begin
        dmem_req = 1'b1;
        stall_o  = 1'b1;
        if (dmem_gnt) w_state_nxt = r_is_load ? MS_RESP : MS_DONE;
      end
      MS_RESP: begin
        stall_o = 1'b1;
        if (dmem_rvalid) w_state_nxt = MS_DONE;
      end
      default: begin
        rd_we_o     = r_is_load && (r_rd_addr != 5'd0);
        rd_addr_o   = r_rd_addr;
        rd_data_o   = r_result;
        w_state_nxt = MS_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_rd_we_i, ex_mem_re_i, ex_mem_we_i;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_alu_res_i, ex_store_data_i;
  logic [2:0]  ex_funct3_i;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        rd_we_o, stall_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
`ifdef MEM_MISALIGN_EXC_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid_i),
    .ex_rd_we_i      (ex_rd_we_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_alu_res_i    (ex_alu_res_i),
    .ex_store_data_i (ex_store_data_i),
    .ex_mem_re_i     (ex_mem_re_i),
    .ex_mem_we_i     (ex_mem_we_i),
    .ex_funct3_i     (ex_funct3_i),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
`ifdef MEM_MISALIGN_EXC_EN
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o),
`endif
    .rd_we_o         (rd_we_o),
    .rd_addr_o       (rd_addr_o),
    .rd_data_o       (rd_data_o),
    .stall_o         (stall_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic re, input logic we, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] sd);
    ex_valid_i      = 1'b1;
    ex_rd_we_i      = re;
    ex_mem_re_i     = re;
    ex_mem_we_i     = we;
    ex_funct3_i     = f3;
    ex_rd_addr_i    = rd;
    ex_alu_res_i    = addr;
    ex_store_data_i = sd;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid_i = 0; ex_rd_we_i = 0; ex_mem_re_i = 0; ex_mem_we_i = 0;
    ex_funct3_i = 0; ex_rd_addr_i = 0; ex_alu_res_i = 0; ex_store_data_i = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    tick(); tick();
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_rdwe", rd_we_o, 0);
    rst = 1'b0;
    tick();

    // ALU pass-through
    set_op(0, 0, 3'b000, 5'd5, 32'h1234, 0);
    ex_rd_we_i = 1'b1;
    #1;
    chk("alu_rdwe", rd_we_o, 1);
    chk("alu_rdaddr", rd_addr_o, 5);
    chk("alu_rddata", rd_data_o, 32'h1234);
    chk("alu_stall", stall_o, 0);
    chk("alu_req", dmem_req, 0);

    // LB addr 0x103, gnt immediate, rvalid next cycle
    set_op(1, 0, 3'b000, 5'd7, 32'h103, 0);
    #1;
    chk("lb_idle_stall", stall_o, 1);
    chk("lb_idle_rdwe", rd_we_o, 0);
    tick();
    chk("lb_req", dmem_req, 1);
    chk("lb_we", dmem_we, 0);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", dmem_be, 4'b1000);
    chk("lb_req_stall", stall_o, 1);
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    chk("lb_resp_req", dmem_req, 0);
    chk("lb_resp_stall", stall_o, 1);
    dmem_rvalid = 1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_rvalid = 0; dmem_rdata = 32'hDEAD_BEEF;
    chk("lb_done_stall", stall_o, 0);
    chk("lb_done_rdwe", rd_we_o, 1);
    chk("lb_done_rdaddr", rd_addr_o, 7);
    chk("lb_done_data", rd_data_o, 32'hFFFF_FF80);
    ex_valid_i = 0;
    tick();
    chk("lb_idle_after_stall", stall_o, 0);
    chk("lb_idle_after_rdwe", rd_we_o, 0);

    // SH addr 0x102, gnt after 2 wait cycles
    set_op(0, 1, 3'b001, 5'd9, 32'h102, 32'hABCD_1234);
    #1;
    chk("sh_idle_stall", stall_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) dmem_gnt = 1;
      chk("sh_req", dmem_req, 1);
      chk("sh_we", dmem_we, 1);
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'h1234_1234);
      chk("sh_addr", dmem_addr, 32'h100);
      chk("sh_stall", stall_o, 1);
    end
    tick();
    dmem_gnt = 0;
    chk("sh_done_stall", stall_o, 0);
    chk("sh_done_rdwe", rd_we_o, 0);
    chk("sh_done_req", dmem_req, 0);
    ex_valid_i = 0;
    tick();

    // SB addr 0x101: byte lane replication, 2-cycle store latency
    set_op(0, 1, 3'b000, 5'd1, 32'h101, 32'h0000_0055);
    #1;
    chk("sb_idle_stall", stall_o, 1);
    tick();
    chk("sb_be", dmem_be, 4'b0010);
    chk("sb_wdata", dmem_wdata, 32'h5555_5555);
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    chk("sb_done_stall", stall_o, 0);
    chk("sb_done_rdwe", rd_we_o, 0);
    ex_valid_i = 0;
    tick();

    // LHU addr 0x200, rvalid after 4 wait cycles
    set_op(1, 0, 3'b101, 5'd3, 32'h200, 0);
    tick();
    chk("lhu_be", dmem_be, 4'b0011);
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    dmem_rdata = 32'h0000_8001;
    for (int i = 0; i < 4; i++) begin
      chk("lhu_resp_stall", stall_o, 1);
      chk("lhu_resp_req", dmem_req, 0);
      tick();
    end
    chk("lhu_wait_end_stall", stall_o, 1);
    dmem_rvalid = 1;
    tick();
    dmem_rvalid = 0;
    chk("lhu_done_data", rd_data_o, 32'h0000_8001);
    chk("lhu_done_rdwe", rd_we_o, 1);
    chk("lhu_done_stall", stall_o, 0);
    ex_valid_i = 0;
    tick();

`ifndef MEM_MISALIGN_EXC_EN
    // LH addr 0x103: addr[0] ignored, upper half sign-extended
    set_op(1, 0, 3'b001, 5'd11, 32'h103, 0);
    tick();
    chk("lh_mis_addr", dmem_addr, 32'h100);
    chk("lh_mis_be", dmem_be, 4'b1100);
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hF00D_1234;
    tick();
    dmem_rvalid = 0;
    chk("lh_mis_data", rd_data_o, 32'hFFFF_F00D);
    ex_valid_i = 0;
    tick();
`else
    // LW addr 0x101: rejected, never reaches the bus
    set_op(1, 0, 3'b010, 5'd6, 32'h101, 0);
    #1;
    chk("mis_flag", misalign_o, 1);
    chk("mis_addr", misalign_addr_o, 32'h101);
    chk("mis_rdwe", rd_we_o, 0);
    chk("mis_stall", stall_o, 0);
    tick();
    chk("mis_req", dmem_req, 0);
    ex_valid_i = 0;
    #1;
    chk("mis_flag_clear", misalign_o, 0);
    tick();
`endif

    // LW with rd=0: word load completes but does not write
    set_op(1, 0, 3'b010, 5'd0, 32'h400, 0);
    tick();
    chk("lw0_be", dmem_be, 4'b1111);
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 0;
    chk("lw0_data", rd_data_o, 32'hCAFE_F00D);
    chk("lw0_rdwe", rd_we_o, 0);
    ex_valid_i = 0;
    tick();

    // Reset during RESP
    set_op(1, 0, 3'b010, 5'd4, 32'h300, 0);
    tick();
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    chk("rstr_resp_stall", stall_o, 1);
    rst = 1; ex_valid_i = 0;
    tick();
    rst = 0;
    chk("rstr_stall", stall_o, 0);
    chk("rstr_req", dmem_req, 0);
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    #1;
    chk("rstr_late_rdwe", rd_we_o, 0);
    tick();
    dmem_rvalid = 0;
    chk("rstr_after_rdwe", rd_we_o, 0);
    chk("rstr_after_stall", stall_o, 0);
    chk("rstr_after_req", dmem_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
